// File: rtl/data_mem_pkg.sv
// Shared types for the data memory arbiter slice.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned DEPTH_DEFAULT = 32;

  // Requester index: 0 = core LSU, 1 = debug/DMA.
  typedef logic port_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; the port not served last wins a tie.
module rr_arbiter2
  import data_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  port_id_t last_port;

  // Remember which port was served; resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_port <= 1'b1;
    end else if (advance) begin
      last_port <= grant[1];
    end
  end

  // One-hot grant derived from the request pair and the last-served port.
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_port ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data RAM, one request in flight.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic              p0_write,
  input  logic [DATA_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  input  logic              p1_valid,
  input  logic              p1_write,
  input  logic [DATA_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              resp_valid,
  output logic              resp_port,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] mem_addr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  state_t            state, state_next;
  logic [1:0]        grant;
  logic              accept;
  port_id_t          lat_port;
  logic              lat_write;
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              in_range;

  assign in_range = (lat_addr < DATA_W'(DEPTH));

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({p1_valid, p0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus all handshake, RAM and response outputs decoded from state.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    p0_ready   = 1'b0;
    p1_ready   = 1'b0;
    mem_addr   = '0;
    write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    resp_valid = 1'b0;
    resp_port  = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE: begin
        p0_ready = grant[0];
        p1_ready = grant[1];
        accept   = |grant;
        if (|grant) state_next = ACCESS;
      end
      ACCESS: begin
        if (in_range) begin
          mem_addr = lat_addr;
          MemRead  = ~lat_write;
          MemWrite = lat_write;
          if (lat_write) write_data = lat_wdata;
        end
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_port  = lat_port;
        resp_err   = rsp_err;
        resp_rdata = rsp_rdata;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch on acceptance and response capture at the end of ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_port  <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        lat_port  <= grant[1];
        lat_write <= grant[1] ? p1_write : p0_write;
        lat_addr  <= grant[1] ? p1_addr  : p0_addr;
        lat_wdata <= grant[1] ? p1_wdata : p0_wdata;
      end
      if (state == ACCESS) begin
        rsp_err   <= ~in_range;
        rsp_rdata <= (in_range && !lat_write) ? read_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a shadow-memory reference model.
module tb_data_mem_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned DP = 32;

  logic          clk;
  logic          reset;
  logic          p0_valid, p0_write, p0_ready;
  logic [DW-1:0] p0_addr, p0_wdata;
  logic          p1_valid, p1_write, p1_ready;
  logic [DW-1:0] p1_addr, p1_wdata;
  logic          resp_valid, resp_port, resp_err, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic [DW-1:0] mem_addr, write_data, read_data;
  logic          MemRead, MemWrite;

  logic [DW-1:0] ram      [DP];
  logic [DW-1:0] init_img [DP];
  logic [DW-1:0] shadow   [DP];
  logic          ram_load;

  int unsigned tests;
  int unsigned fails;
  bit          last_m;

  data_mem_arbiter #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk        (clk),
    .reset      (reset),
    .p0_valid   (p0_valid),
    .p0_write   (p0_write),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p0_ready   (p0_ready),
    .p1_valid   (p1_valid),
    .p1_write   (p1_write),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p1_ready   (p1_ready),
    .resp_valid (resp_valid),
    .resp_port  (resp_port),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .resp_ready (resp_ready),
    .mem_addr   (mem_addr),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: combinational read, write on the strobe.
  assign read_data = (mem_addr < DW'(DP)) ? ram[mem_addr[4:0]] : '0;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < DP; i++) ram[i] <= init_img[i];
    end else if (MemWrite && mem_addr < DW'(DP)) begin
      ram[mem_addr[4:0]] <= write_data;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    p0_valid = 1'($urandom); p0_write = 1'($urandom);
    p0_addr  = {$urandom, $urandom}; p0_wdata = {$urandom, $urandom};
    p1_valid = 1'($urandom); p1_write = 1'($urandom);
    p1_addr  = {$urandom, $urandom}; p1_wdata = {$urandom, $urandom};
  endtask

  task automatic idle_inputs();
    p0_valid = 0; p0_write = 0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 0; p1_write = 0; p1_addr = '0; p1_wdata = '0;
    resp_ready = 0;
  endtask

  // One full transaction: accept, ACCESS strobe, RESP held 'hold' extra cycles.
  task automatic run_txn(input bit v0, input bit w0, input logic [DW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit w1, input logic [DW-1:0] a1, input logic [DW-1:0] d1,
                         input int unsigned hold, input bit poke_addr);
    bit            g, ew, ee;
    logic [DW-1:0] ea, ed, er;
    @(negedge clk);
    p0_valid = v0; p0_write = w0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_write = w1; p1_addr = a1; p1_wdata = d1;
    resp_ready = 0;
    #1;
    g = (v0 && v1) ? ~last_m : v1;
    chk("p0_ready_accept", p0_ready, g == 1'b0);
    chk("p1_ready_accept", p1_ready, g == 1'b1);
    last_m = g;
    ea = g ? a1 : a0;
    ew = g ? w1 : w0;
    ed = g ? d1 : d0;
    ee = (ea >= DW'(DP));
    er = (ee || ew) ? '0 : shadow[ea[4:0]];
    if (!ee && ew) shadow[ea[4:0]] = ed;
    @(negedge clk);
    scramble();
    #1;
    chk("MemWrite_access", MemWrite, !ee && ew);
    chk("MemRead_access", MemRead, !ee && !ew);
    chk("mem_addr_access", mem_addr, ee ? '0 : ea);
    if (ew) chk("write_data_access", write_data, ee ? '0 : ed);
    chk("ready_access", {p1_ready, p0_ready}, 2'b00);
    chk("resp_valid_access", resp_valid, 1'b0);
    for (int unsigned i = 0; i <= hold; i++) begin
      @(negedge clk);
      if (poke_addr) p0_addr = ~p0_addr;
      else scramble();
      resp_ready = (i == hold);
      #1;
      chk("resp_valid", resp_valid, 1'b1);
      chk("resp_port", resp_port, g);
      chk("resp_err", resp_err, ee);
      chk("resp_rdata", resp_rdata, er);
      chk("ready_resp", {p1_ready, p0_ready}, 2'b00);
      chk("strobes_resp", {MemRead, MemWrite}, 2'b00);
    end
  endtask

  initial begin
    bit            rv0, rv1;
    logic [DW-1:0] ra0, ra1;
    tests = 0;
    fails = 0;
    last_m = 1'b1;
    reset = 0;
    ram_load = 1;
    idle_inputs();
    for (int i = 0; i < DP; i++) begin
      init_img[i] = {$urandom, $urandom};
      shadow[i]   = init_img[i];
    end
    #1;
    chk("rst_ready", {p1_ready, p0_ready}, 2'b00);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_port", resp_port, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_rdata", resp_rdata, '0);
    chk("rst_strobes", {MemRead, MemWrite}, 2'b00);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_write_data", write_data, '0);
    repeat (2) @(negedge clk);
    ram_load = 0;
    reset = 1;

    // Both ports valid continuously: grants alternate starting with port 0.
    for (int k = 0; k < 4; k++)
      run_txn(1, 0, 64'd1, '0, 1, 0, 64'd2, '0, 0, 0);

    // Store then load back on port 0.
    run_txn(1, 1, 64'd5, 64'hDEAD_BEEF, 0, 0, '0, '0, 0, 0);
    run_txn(1, 0, 64'd5, '0, 0, 0, '0, '0, 0, 0);
    chk("load_back_5", shadow[5], 64'hDEAD_BEEF);

    // Out-of-range load on port 1, including a value that aliases in the low bits.
    run_txn(0, 0, '0, '0, 1, 0, 64'd40, '0, 0, 0);
    run_txn(0, 0, '0, '0, 1, 0, 64'h1_0000_0005, '0, 0, 0);

    // Response held off for 5 cycles while port 0 address keeps changing.
    run_txn(1, 0, 64'd5, '0, 0, 0, '0, '0, 5, 1);

    // Reset during ACCESS of a port 0 store: strobe drops, no response, p0 wins next.
    @(negedge clk);
    idle_inputs();
    p0_valid = 1; p0_write = 1; p0_addr = 64'd7; p0_wdata = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("abort_accept", p0_ready, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("abort_memwrite_pre", MemWrite, 1'b1);
    reset = 0;
    #1;
    chk("abort_memwrite_drop", MemWrite, 1'b0);
    chk("abort_mem_addr", mem_addr, '0);
    chk("abort_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    reset = 1;
    last_m = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("abort_no_resp", resp_valid, 1'b0);
    end
    run_txn(1, 0, 64'd7, '0, 1, 0, 64'd8, '0, 0, 0);

    // Randomized traffic against the shadow model.
    for (int k = 0; k < 150; k++) begin
      rv0 = 1'($urandom);
      rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv0 = 1;
      ra0 = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 39));
      ra1 = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 39));
      run_txn(rv0, 1'($urandom), ra0, {$urandom, $urandom},
              rv1, 1'($urandom), ra1, {$urandom, $urandom},
              $urandom_range(0, 3), 0);
    end

    @(negedge clk);
    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter DATA_W, 64, width of data and address buses.
REQ-002 Parameter DEPTH, 32, number of words in the shared data RAM; legal addresses are 0..DEPTH-1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserted when 0.
REQ-005 pN_valid  in  1  requester N (N=0 core LSU, N=1 debug/DMA) has a request.
REQ-006 pN_write  in  1  1 = store, 0 = load.
REQ-007 pN_addr  in  DATA_W  word address.
REQ-008 pN_wdata  in  DATA_W  store data.
REQ-009 pN_ready  out  1  request of port N accepted this cycle.
REQ-010 resp_valid  out  1  response available.
REQ-011 resp_port  out  1  index of the port the response belongs to.
REQ-012 resp_err  out  1  address out of range; no RAM access took place.
REQ-013 resp_rdata  out  DATA_W  load data; 0 for stores and errors.
REQ-014 resp_ready  in  1  consumer takes the response.
REQ-015 mem_addr  out  DATA_W  RAM address.
REQ-016 MemRead  out  1  RAM read strobe.
REQ-017 MemWrite  out  1  RAM write strobe.
REQ-018 write_data  out  DATA_W  RAM write data.
REQ-019 read_data  in  DATA_W  RAM combinational read data.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS and RESP; exactly one request SHALL be in flight at any time.
REQ-021 In IDLE, pN_ready SHALL be asserted combinationally only for the granted port, and only when that port's pN_valid=1; in ACCESS and RESP both readies SHALL be 0.
REQ-022 Arbitration SHALL be round-robin: if only one port is valid, it is granted; if both are valid, the port not served by the last accepted request is granted.
REQ-023 On acceptance (valid & ready), the controller SHALL latch port, write, addr and wdata and move IDLE->ACCESS.
REQ-024 In ACCESS, for an in-range address, the controller SHALL drive mem_addr, write_data and exactly one of MemRead/MemWrite for exactly one cycle, capture read_data on a load at the clock edge, and move ACCESS->RESP.
REQ-025 If the address is >= DEPTH, ACCESS SHALL assert neither strobe, and the response SHALL carry resp_err=1 and resp_rdata=0.
REQ-026 Outside ACCESS, MemRead, MemWrite, mem_addr and write_data SHALL be 0.
REQ-027 In RESP, resp_valid SHALL be 1, and resp_port, resp_err and resp_rdata SHALL be held stable until resp_ready=1; then the FSM SHALL move RESP->IDLE.
REQ-028 Latency SHALL be: accept at cycle N, strobe at N+1, resp_valid from N+2; a back-to-back accept is possible at the cycle after resp_ready.
REQ-029 A store SHALL produce a response with resp_rdata=0 and resp_err=0.
REQ-030 Changes to pN_* inputs while a request is in flight SHALL have no effect on it.

Reset
REQ-031 While reset=0, the FSM SHALL be IDLE, and all outputs and latched request/response registers SHALL be 0.
REQ-032 The round-robin pointer SHALL reset so that port 0 wins the first simultaneous request.
REQ-033 Reset asserted mid-ACCESS or mid-RESP SHALL drop the in-flight request with no response and deassert the strobes immediately.

Structure
REQ-034 Package data_mem_pkg SHALL hold the FSM state enum, the DEPTH default, and the port-id type.
REQ-035 Two-port round-robin grant logic SHALL be a sub-module named rr_arbiter2 (inputs req[1:0] and an advance pulse; output grant[1:0]).

Verification
REQ-036 Scenario: p0 store addr 5 data 0xDEAD_BEEF, then p0 load addr 5 -> MemWrite one cycle with mem_addr=5, then resp_rdata=0xDEADBEEF and resp_err=0 at accept+2.
REQ-037 Scenario: p0 and p1 both valid continuously after reset -> grants alternate p0, p1, p0, p1, and resp_port follows the same order.
REQ-038 Scenario: p1 load addr 40 -> no MemRead/MemWrite pulse, then resp_err=1, resp_rdata=0 and resp_port=1.
REQ-039 Scenario: resp_ready held 0 for 5 cycles -> resp_valid and resp data stable for all 5 cycles, pN_ready=0 throughout, and no RAM strobes.
REQ-040 Scenario: reset pulled low during ACCESS of a p0 store -> MemWrite drops immediately, no response is produced, and the next simultaneous request grants p0.
REQ-041 Scenario: p0_addr changed during RESP -> response data is unchanged.
